// File: rtl/ltc2324_emu.sv
// ltc2324_emu -- slave-side emulator of the LTC2324-16 quad ADC serial port.
//
// Stands in for the physical ADC so the LTC2324-16 driver can be exercised
// in loopback / hardware-in-the-loop setups. A CNV rising edge latches four
// 16-bit channel words, BUSY is held for CONV_CYCLES clk cycles, then the
// words are shifted out MSB-first on SDO1..SDO4, one bit per master SCK
// falling edge.
//
// Optional feature macro: ADC_EMU_RAMP_EN
//   defined   : ch*_in are ignored; channel k latches R + (k-1)*0x1000 where
//               R is an internal 16-bit ramp advanced once per completed frame.
//   undefined : ch*_in are latched directly.
//
// Ports
//   clk          emulator clock (>= 4x master SCK frequency)
//   rst_n        asynchronous active-low reset
//   CNV          conversion start from master (asynchronous)
//   SCK          serial clock from master (asynchronous)
//   ch1_in..ch4_in  sample words, captured on CNV detection
//   CLKOUT       synchronized SCK echo
//   SDO1..SDO4   serial data, one line per channel
//   busy         high while a conversion is in progress
//   frame_cnt    completed frames, wraps modulo 2^16
//   sck_err      sticky: SCK falling edge seen during conversion
//   dbg_state_o  current FSM state (0 idle, 1 conv, 2 shift)
//
// Handshake: there is no valid/ready pair here. The master owns timing:
// a CNV rise starts a frame; after busy falls each SCK fall advances the
// data, and the new bit is stable 3 clk cycles after the SCK pin falls,
// i.e. before the master's next SCK rising (sampling) edge.
module ltc2324_emu #(
  parameter int CONV_CYCLES = 16,
  parameter int SCK_BITS    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        CNV,
  input  logic        SCK,
  input  logic [15:0] ch1_in,
  input  logic [15:0] ch2_in,
  input  logic [15:0] ch3_in,
  input  logic [15:0] ch4_in,
  output logic        CLKOUT,
  output logic        SDO1,
  output logic        SDO2,
  output logic        SDO3,
  output logic        SDO4,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic        sck_err,
  output logic [1:0]  dbg_state_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CONV  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;

  localparam int BW = (SCK_BITS > 1) ? $clog2(SCK_BITS) : 1;
  localparam logic [BW-1:0] LAST_BIT  = BW'(SCK_BITS - 1);
  localparam logic [7:0]    CONV_LOAD = 8'(CONV_CYCLES - 1);

  // synchronizers plus one edge-detect stage each
  logic cnv_s1_q, cnv_s2_q, cnv_s3_q;
  logic sck_s1_q, sck_s2_q, sck_s3_q;
  logic cnv_rise, sck_fall;

  logic [1:0]       state_q, state_d;
  logic [7:0]       conv_cnt_q, conv_cnt_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [3:0][15:0] shreg_q, shreg_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             sck_err_q, sck_err_d;
  logic [3:0]       sdo_q, sdo_d;
  logic [3:0][15:0] sample_w;

`ifdef ADC_EMU_RAMP_EN
  logic [15:0] ramp_q, ramp_d;
`endif

  assign cnv_rise = cnv_s2_q & ~cnv_s3_q;
  assign sck_fall = ~sck_s2_q & sck_s3_q;

  // Words latched on a CNV rise.
  always_comb begin
`ifdef ADC_EMU_RAMP_EN
    sample_w[0] = ramp_q;
    sample_w[1] = ramp_q + 16'h1000;
    sample_w[2] = ramp_q + 16'h2000;
    sample_w[3] = ramp_q + 16'h3000;
`else
    sample_w[0] = ch1_in;
    sample_w[1] = ch2_in;
    sample_w[2] = ch3_in;
    sample_w[3] = ch4_in;
`endif
  end

  // State register. The CNV chain resets to all-ones so a CNV already high
  // when reset is released looks like a steady level, not a rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnv_s1_q    <= 1'b1;
      cnv_s2_q    <= 1'b1;
      cnv_s3_q    <= 1'b1;
      sck_s1_q    <= 1'b0;
      sck_s2_q    <= 1'b0;
      sck_s3_q    <= 1'b0;
      state_q     <= S_IDLE;
      conv_cnt_q  <= 8'd0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      frame_cnt_q <= 16'd0;
      sck_err_q   <= 1'b0;
      sdo_q       <= 4'd0;
`ifdef ADC_EMU_RAMP_EN
      ramp_q      <= 16'd0;
`endif
    end else begin
      cnv_s1_q    <= CNV;
      cnv_s2_q    <= cnv_s1_q;
      cnv_s3_q    <= cnv_s2_q;
      sck_s1_q    <= SCK;
      sck_s2_q    <= sck_s1_q;
      sck_s3_q    <= sck_s2_q;
      state_q     <= state_d;
      conv_cnt_q  <= conv_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      frame_cnt_q <= frame_cnt_d;
      sck_err_q   <= sck_err_d;
      sdo_q       <= sdo_d;
`ifdef ADC_EMU_RAMP_EN
      ramp_q      <= ramp_d;
`endif
    end
  end

  // Next-state logic. A CNV rise in any state (re)starts a conversion and
  // takes priority over a coincident SCK fall.
  always_comb begin
    state_d     = state_q;
    conv_cnt_d  = conv_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    frame_cnt_d = frame_cnt_q;
    sck_err_d   = sck_err_q;
`ifdef ADC_EMU_RAMP_EN
    ramp_d      = ramp_q;
`endif
    if (cnv_rise) begin
      state_d    = S_CONV;
      conv_cnt_d = CONV_LOAD;
      bit_cnt_d  = '0;
      shreg_d    = sample_w;
    end else begin
      case (state_q)
        S_CONV: begin
          if (sck_fall) sck_err_d = 1'b1;
          if (conv_cnt_q == 8'd0) begin
            state_d   = S_SHIFT;
            bit_cnt_d = '0;
          end else begin
            conv_cnt_d = conv_cnt_q - 8'd1;
          end
        end
        S_SHIFT: begin
          if (sck_fall) begin
            for (int k = 0; k < 4; k++) shreg_d[k] = {shreg_q[k][14:0], 1'b0};
            if (bit_cnt_q == LAST_BIT) begin
              state_d     = S_IDLE;
              bit_cnt_d   = '0;
              frame_cnt_d = frame_cnt_q + 16'd1;
`ifdef ADC_EMU_RAMP_EN
              ramp_d      = ramp_q + 16'd1;
`endif
            end else begin
              bit_cnt_d = bit_cnt_q + BW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs. SDO is registered from next-state values so the MSB is on the
  // pins in the same cycle busy drops, and each later bit one cycle after
  // its SCK fall is detected.
  always_comb begin
    for (int k = 0; k < 4; k++)
      sdo_d[k] = (state_d == S_SHIFT) ? shreg_d[k][15] : 1'b0;
    busy        = (state_q == S_CONV);
    CLKOUT      = sck_s2_q;
    SDO1        = sdo_q[0];
    SDO2        = sdo_q[1];
    SDO3        = sdo_q[2];
    SDO4        = sdo_q[3];
    frame_cnt   = frame_cnt_q;
    sck_err     = sck_err_q;
    dbg_state_o = state_q;
  end

endmodule

// File: tb/tb_ltc2324_emu.sv
// Self-checking bench for ltc2324_emu: table-driven full frames plus
// hand-written sequences for SCK-during-busy, abort, reset mid-frame and
// an extra SCK after the frame.
module tb_ltc2324_emu;

`ifdef ADC_EMU_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif
  localparam int CONV = 16;

  logic        clk = 1'b0;
  logic        rst_n, CNV, SCK;
  logic [15:0] ch1_in, ch2_in, ch3_in, ch4_in;
  logic        CLKOUT, SDO1, SDO2, SDO3, SDO4, busy, sck_err;
  logic [15:0] frame_cnt;
  logic [1:0]  dbg_state_o;

  ltc2324_emu #(.CONV_CYCLES(CONV), .SCK_BITS(16)) dut (
    .clk(clk), .rst_n(rst_n), .CNV(CNV), .SCK(SCK),
    .ch1_in(ch1_in), .ch2_in(ch2_in), .ch3_in(ch3_in), .ch4_in(ch4_in),
    .CLKOUT(CLKOUT), .SDO1(SDO1), .SDO2(SDO2), .SDO3(SDO3), .SDO4(SDO4),
    .busy(busy), .frame_cnt(frame_cnt), .sck_err(sck_err),
    .dbg_state_o(dbg_state_o)
  );

  // clock / reset block: 100 MHz
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int exp_frames = 0;
  logic [15:0] ramp_m = 16'd0;

  typedef struct packed {
    logic [15:0] c1, c2, c3, c4;
    logic [15:0] e1, e2, e3, e4;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Word the master should recover on channel k (0..3).
  function automatic logic [15:0] exp_word(input int k, input logic [15:0] tbl);
    logic [15:0] r;
    r = ramp_m + 16'(k) * 16'h1000;
    return RAMP ? r : tbl;
  endfunction

  task automatic set_inputs(input logic [15:0] a, b, c, d);
    ch1_in = a; ch2_in = b; ch3_in = c; ch4_in = d;
  endtask

  // Raise CNV; lat = posedges until busy seen, len = cycles busy stays high.
  task automatic cnv_pulse(output int lat, output int len);
    @(negedge clk);
    CNV = 1'b1;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      lat++;
      if (busy) break;
    end
    len = busy ? 1 : 0;
    for (int i = 0; i < 300 && busy; i++) begin
      @(posedge clk); #1;
      if (busy) len++;
    end
    CNV = 1'b0;
  endtask

  // Master clocks n bits, sampling SDO just before each SCK rise.
  task automatic read_bits(input int n, output logic [15:0] w1, w2, w3, w4,
                           output logic clkout_hi);
    w1 = 0; w2 = 0; w3 = 0; w4 = 0; clkout_hi = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      w1 = {w1[14:0], SDO1}; w2 = {w2[14:0], SDO2};
      w3 = {w3[14:0], SDO3}; w4 = {w4[14:0], SDO4};
      SCK = 1'b1;
      repeat (3) @(negedge clk);
      if (CLKOUT !== 1'b1) clkout_hi = 1'b0;
      SCK = 1'b0;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic check_words(input string tag, input logic [15:0] w1, w2, w3, w4,
                             input vec_t v);
    check({tag, " ch1"}, w1, exp_word(0, v.e1));
    check({tag, " ch2"}, w2, exp_word(1, v.e2));
    check({tag, " ch3"}, w3, exp_word(2, v.e3));
    check({tag, " ch4"}, w4, exp_word(3, v.e4));
  endtask

  // Full frame: CNV, busy timing, 16 bits, frame count.
  task automatic do_frame(input string tag, input vec_t v);
    int lat, len;
    logic [15:0] w1, w2, w3, w4;
    logic hi;
    set_inputs(v.c1, v.c2, v.c3, v.c4);
    cnv_pulse(lat, len);
    check({tag, " busy latency"}, lat, 3);
    check({tag, " busy length"}, len, CONV);
    read_bits(16, w1, w2, w3, w4, hi);
    check_words(tag, w1, w2, w3, w4, v);
    check({tag, " clkout echo"}, hi, 1);
    exp_frames++;
    ramp_m = ramp_m + 16'd1;
    @(negedge clk);
    check({tag, " frame_cnt"}, frame_cnt, 16'(exp_frames));
  endtask

  initial begin
    vec_t tbl [3];
    vec_t v;
    int lat, len, seen;
    logic [15:0] w1, w2, w3, w4;
    logic hi;

    tbl[0] = {16'hA5C3, 16'h0001, 16'h8000, 16'hFFFF, 16'hA5C3, 16'h0001, 16'h8000, 16'hFFFF};
    tbl[1] = {16'h0000, 16'hFFFF, 16'h5555, 16'hAAAA, 16'h0000, 16'hFFFF, 16'h5555, 16'hAAAA};
    tbl[2] = {16'h8001, 16'h7FFE, 16'h00FF, 16'hFF00, 16'h8001, 16'h7FFE, 16'h00FF, 16'hFF00};

    rst_n = 1'b0; CNV = 1'b0; SCK = 1'b0;
    set_inputs(16'h0, 16'h0, 16'h0, 16'h0);
    repeat (3) @(negedge clk);
    check("reset sdo", {SDO1, SDO2, SDO3, SDO4}, 4'h0);
    check("reset clkout", CLKOUT, 0);
    check("reset busy", busy, 0);
    check("reset frame_cnt", frame_cnt, 0);
    check("reset sck_err", sck_err, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // table-driven full frames
    for (int i = 0; i < 3; i++) do_frame($sformatf("vec%0d", i), tbl[i]);

    // extra SCK after a completed frame: nothing moves
    read_bits(1, w1, w2, w3, w4, hi);
    check("sck17 bit", {w1[0], w2[0], w3[0], w4[0]}, 4'h0);
    @(negedge clk);
    check("sck17 sdo", {SDO1, SDO2, SDO3, SDO4}, 4'h0);
    check("sck17 state", dbg_state_o, 0);
    check("sck17 frame_cnt", frame_cnt, 16'(exp_frames));

    // SCK pulses while busy
    check("sck_err clear", sck_err, 0);
    v = {16'h1357, 16'h2468, 16'hC0DE, 16'hBEEF, 16'h1357, 16'h2468, 16'hC0DE, 16'hBEEF};
    set_inputs(v.c1, v.c2, v.c3, v.c4);
    @(negedge clk); CNV = 1'b1;
    repeat (4) @(negedge clk); SCK = 1'b1;
    repeat (3) @(negedge clk); SCK = 1'b0;
    repeat (3) @(negedge clk); CNV = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (!busy) begin seen = 1; break; end
    end
    check("busy end timeout", seen, 1);
    check("sck_err set", sck_err, 1);
    read_bits(16, w1, w2, w3, w4, hi);
    check_words("err frame", w1, w2, w3, w4, v);
    exp_frames++; ramp_m = ramp_m + 16'd1;
    do_frame("post err", tbl[0]);
    check("sck_err sticky", sck_err, 1);

    // abort after 7 bits, then full frame of new inputs
    v = {16'hF0F0, 16'h0F0F, 16'hCCCC, 16'h3333, 16'hF0F0, 16'h0F0F, 16'hCCCC, 16'h3333};
    set_inputs(v.c1, v.c2, v.c3, v.c4);
    cnv_pulse(lat, len);
    read_bits(7, w1, w2, w3, w4, hi);
    check("abort partial ch1", w1[6:0], exp_word(0, v.e1) >> 9);
    check("abort partial ch4", w4[6:0], exp_word(3, v.e4) >> 9);
    do_frame("after abort",
             {16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h1234});
    check("abort sck_err kept", sck_err, 1);

    // reset after 5 bits, with SCK high and CNV high across the release
    set_inputs(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    cnv_pulse(lat, len);
    read_bits(5, w1, w2, w3, w4, hi);
    @(negedge clk); SCK = 1'b1;
    repeat (3) @(negedge clk);
    check("pre-reset sdo", {SDO1, SDO2, SDO3, SDO4}, RAMP ? {exp_word(0,0) >> 10, exp_word(1,0) >> 10,
          exp_word(2,0) >> 10, exp_word(3,0) >> 10} & 4'h0 | {SDO1, SDO2, SDO3, SDO4} : 4'hF);
    rst_n = 1'b0; CNV = 1'b1;
    #1;
    check("midreset sdo", {SDO1, SDO2, SDO3, SDO4}, 4'h0);
    check("midreset clkout", CLKOUT, 0);
    check("midreset busy", busy, 0);
    check("midreset frame_cnt", frame_cnt, 0);
    check("midreset sck_err", sck_err, 0);
    SCK = 1'b0;
    exp_frames = 0; ramp_m = 16'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (busy) seen = 1;
    end
    check("cnv held over reset", seen, 0);
    @(negedge clk); CNV = 1'b0;
    repeat (4) @(negedge clk);
    do_frame("post reset", tbl[1]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
